adder_share_ctrl: RTL and testbench

- Shares one 32-bit add/sub datapath (adder32) among NREQ requesters.
- Arbitration is round-robin.
- Each operation has a registered compute stage and a single shared, held response channel.
- Sits between the lab's operand producers (ALU-lab front ends, test drivers) and the adder core, so several clients can use one physical adder without contention.

---
 rtl/adder_share_ctrl_pkg.sv | 15 +
 rtl/adder_share_ctrl_adder32.sv | 14 +
 rtl/adder_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/adder_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_adder_share_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the adder-sharing controller.
package adder_share_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/adder_share_ctrl_adder32.sv
// Shared 32-bit adder core with carry-in and signed-overflow output.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        ovf
);

  assign sum = a + b + 32'(cin);
  // b is already inverted for subtract, so one rule covers both operations
  assign ovf = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester above ptr (with wrap) wins.
// The pointer register itself lives in the controller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && req[idx] && !found) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sharing of one adder32 among NREQ requesters with a held response channel.
// Optional statistics counters are enabled by defining ADDER_SHARE_STATS_EN.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*32-1:0] req_op1,
  input  logic [NREQ*32-1:0] req_op2,
  input  logic [NREQ-1:0]  req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [31:0]      resp_sum,
  output logic             resp_flag,
  output logic [15:0]      op_count,
  output logic [15:0]      ovf_count
);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            op_q;
  logic [IDW-1:0]  id_q;

  logic            arb_en;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [31:0]     sel_op1;
  logic [31:0]     sel_op2;
  logic            sel_op;
  logic [31:0]     add_b;
  logic [31:0]     add_sum;
  logic            add_ovf;

  // Grants only in IDLE, or in RESP when the current response is being taken
  assign arb_en = !rst && ((state == S_IDLE) || ((state == S_RESP) && resp_ready));

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_op1   = req_op1[32*int'(grant_idx) +: 32];
  assign sel_op2   = req_op2[32*int'(grant_idx) +: 32];
  assign sel_op    = req_op[grant_idx];
  assign add_b     = (op_q == OP_SUB) ? ~b_q : b_q;

  adder32 u_add (
    .a   (a_q),
    .b   (add_b),
    .cin (op_q),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= IDW'(NREQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      id_q       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q    <= sel_op1;
            b_q    <= sel_op2;
            op_q   <= sel_op;
            id_q   <= grant_idx;
            rr_ptr <= grant_idx;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          resp_sum   <= add_sum;
          resp_flag  <= add_ovf;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (accept) begin
              a_q    <= sel_op1;
              b_q    <= sel_op2;
              op_q   <= sel_op;
              id_q   <= grant_idx;
              rr_ptr <= grant_idx;
              state  <= S_CALC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADDER_SHARE_STATS_EN
  logic [STAT_W-1:0] op_cnt;
  logic [STAT_W-1:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt  <= '0;
      ovf_cnt <= '0;
    end else if (resp_valid && resp_ready) begin
      if (op_cnt != '1) op_cnt <= op_cnt + 1'b1;
      if (resp_flag && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign op_count  = op_cnt;
  assign ovf_count = ovf_cnt;
`else
  assign op_count  = '0;
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed and random operations
// checked against a signed-arithmetic reference model with round-robin winner prediction.
module tb_adder_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*32-1:0] req_op1;
  logic [NREQ*32-1:0] req_op2;
  logic [NREQ-1:0]  req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [31:0]      resp_sum;
  logic             resp_flag;
  logic [15:0]      op_count;
  logic [15:0]      ovf_count;

  int tests = 0;
  int fails = 0;
  int last  = NREQ - 1;
  int exp_ops = 0;
  int exp_ovf = 0;

  adder_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_flag  (resp_flag),
    .op_count   (op_count),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next winner: first valid requester after the last granted one, wrapping
  function automatic int model_winner(input logic [NREQ-1:0] v, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return 0;
  endfunction

  // Exact signed arithmetic; overflow means the 32-bit result no longer represents it
  function automatic void model_calc(input logic [31:0] a, input logic [31:0] b, input logic op,
                                     output logic [31:0] s, output logic f);
    longint r;
    r = op ? (longint'($signed(a)) - longint'($signed(b)))
           : (longint'($signed(a)) + longint'($signed(b)));
    s = r[31:0];
    f = (r != longint'($signed(s)));
  endfunction

  function automatic int stat_exp(input int n);
`ifdef ADDER_SHARE_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_op1[idx*32 +: 32] = a;
    req_op2[idx*32 +: 32] = b;
    req_op[idx]           = op;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_sum", resp_sum, 0);
    chk("rst_resp_flag", 32'(resp_flag), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    rst     = 1'b0;
    last    = NREQ - 1;
    exp_ops = 0;
    exp_ovf = 0;
  endtask

  // Single-requester operation from IDLE with resp_ready held high
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] es;
    logic        ef;
    int          w;
    set_req(idx, a, b, op);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    #1;
    w = model_winner(req_valid, last);
    chk("op_grant", 32'(req_ready), 32'd1 << w);
    model_calc(a, b, op, es, ef);
    last = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("op_calc_resp_valid", 32'(resp_valid), 0);
    chk("op_calc_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("op_resp_valid", 32'(resp_valid), 1);
    chk("op_resp_id", 32'(resp_id), 32'(w));
    chk("op_resp_sum", resp_sum, es);
    chk("op_resp_flag", 32'(resp_flag), 32'(ef));
    exp_ops++;
    if (ef) exp_ovf++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] es, ef_w, hs;
    logic        ef, hf;
    int          w, hid;

    rst        = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_op     = '0;
    resp_ready = 1'b0;

    // Directed arithmetic cases
    do_reset();
    resp_ready = 1'b1;
    do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    do_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1);
    do_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(1, 32'h0000_0000, 32'h8000_0000, 1'b1);

    // Random single-requester operations
    for (int i = 0; i < 12; i++)
      do_op($urandom_range(0, NREQ - 1), $urandom, $urandom, 1'($urandom_range(0, 1)));
    chk("stat_op_count", 32'(op_count), 32'(stat_exp(exp_ops)));
    chk("stat_ovf_count", 32'(ovf_count), 32'(stat_exp(exp_ovf)));

    // Fairness: all requesters valid from reset, back-to-back grants
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      w = model_winner(req_valid, last);
      chk("fair_grant", 32'(req_ready), 32'd1 << w);
      model_calc(req_op1[w*32 +: 32], req_op2[w*32 +: 32], req_op[w], es, ef);
      last = w;
      @(posedge clk);
      @(negedge clk);
      chk("fair_calc_req_ready", 32'(req_ready), 0);
      chk("fair_calc_resp_valid", 32'(resp_valid), 0);
      set_req(w, $urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk);
      @(negedge clk);
      chk("fair_resp_valid", 32'(resp_valid), 1);
      chk("fair_order", 32'(resp_id), 32'(n % NREQ));
      chk("fair_resp_sum", resp_sum, es);
      chk("fair_resp_flag", 32'(resp_flag), 32'(ef));
    end
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);

    // Backpressure: response held while resp_ready is low
    resp_ready = 1'b0;
    set_req(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    req_valid = 4'b0010;
    #1;
    w = model_winner(req_valid, last);
    chk("bp_grant", 32'(req_ready), 32'd1 << w);
    model_calc(req_op1[w*32 +: 32], req_op2[w*32 +: 32], req_op[w], hs, hf);
    hid  = w;
    last = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    set_req(2, $urandom, $urandom, 1'($urandom_range(0, 1)));
    req_valid = 4'b0100;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_hold_valid", 32'(resp_valid), 1);
      chk("bp_hold_id", 32'(resp_id), 32'(hid));
      chk("bp_hold_sum", resp_sum, hs);
      chk("bp_hold_flag", 32'(resp_flag), 32'(hf));
      chk("bp_no_ready", 32'(req_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    w = model_winner(req_valid, last);
    chk("bp_release_grant", 32'(req_ready), 32'd1 << w);
    model_calc(req_op1[w*32 +: 32], req_op2[w*32 +: 32], req_op[w], es, ef);
    last = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("bp_dropped_valid", 32'(resp_valid), 0);
    @(posedge clk);
    @(negedge clk);
    ef_w = 32'(ef);
    chk("bp_next_id", 32'(resp_id), 32'(w));
    chk("bp_next_sum", resp_sum, es);
    chk("bp_next_flag", 32'(resp_flag), ef_w);
    @(posedge clk);
    @(negedge clk);

    // Reset while an operation is in CALC
    set_req(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_op_count", 32'(op_count), 0);
    chk("midrst_ovf_count", 32'(ovf_count), 0);
    rst     = 1'b0;
    last    = NREQ - 1;
    exp_ops = 0;
    exp_ovf = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_stays_idle", 32'(resp_valid), 0);

    // Three completed operations, one overflowing
    do_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    do_op(3, 32'h7FFF_FFFF, 32'h0000_0002, 1'b0);
    do_op(2, 32'h0000_0009, 32'h0000_0004, 1'b1);
    chk("final_op_count", 32'(op_count), 32'(stat_exp(exp_ops)));
    chk("final_ovf_count", 32'(ovf_count), 32'(stat_exp(exp_ovf)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
